// File: rtl/sum16_seq.sv
// Nibble-serial add/subtract sequencer: one shared 4-bit ripple adder is stepped
// across the operand nibbles, with the carry registered between nibbles.

module sum4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic [3:0] Q,
  output logic       OVF
);

  logic [4:0] c_s;

  // four-bit ripple of full adders; OVF is the carry out of bit 3
  always_comb begin
    c_s    = 5'b00000;
    Q      = 4'b0000;
    c_s[0] = C0;
    for (int i = 0; i < 4; i++) begin
      Q[i]     = A[i] ^ B[i] ^ c_s[i];
      c_s[i+1] = (A[i] & B[i]) | (c_s[i] & (A[i] ^ B[i]));
    end
    OVF = c_s[4];
  end

endmodule

module sum16_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 SUB,
  input  logic                 CIN,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] Q,
  output logic                 COUT,
  output logic                 OVF,
  output logic                 ZERO
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    a_r, b_r, acc_r, acc_nxt_s, q_r;
  logic            sub_r, carry_r;
  logic            busy_r, done_r, cout_r, ovf_r, zero_r;
  logic [3:0]      a_nib_s, b_nib_s, sum_s;
  logic            co_s, last_s, msb_cin_s, start_acc_s;

  // select the active nibble and splice the adder result into the accumulator
  always_comb begin
    a_nib_s   = 4'b0000;
    b_nib_s   = 4'b0000;
    acc_nxt_s = acc_r;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_r == IW'(n)) begin
        a_nib_s = a_r[4*n +: 4];
        b_nib_s = b_r[4*n +: 4] ^ {4{sub_r}};
      end else begin
        a_nib_s = a_nib_s;
        b_nib_s = b_nib_s;
      end
    end
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_r == IW'(n)) begin
        acc_nxt_s[4*n +: 4] = sum_s;
      end else begin
        acc_nxt_s[4*n +: 4] = acc_r[4*n +: 4];
      end
    end
  end

  sum4 u_sum4 (
    .A   (a_nib_s),
    .B   (b_nib_s),
    .C0  (carry_r),
    .Q   (sum_s),
    .OVF (co_s)
  );

  assign last_s      = (idx_r == IW'(NIBBLES - 1));
  // carry into the MSB falls out of the top bit's sum equation
  assign msb_cin_s   = a_nib_s[3] ^ b_nib_s[3] ^ sum_s[3];
  assign start_acc_s = START & ((state_r == ST_IDLE) | (state_r == ST_DONE));

  // next-state decode; START is only honoured outside RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (START) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register plus registered status strobes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // operand capture, nibble stepping and result publication
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      acc_r   <= {W{1'b0}};
      q_r     <= {W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else if (start_acc_s) begin
      a_r     <= A;
      b_r     <= B;
      sub_r   <= SUB;
      carry_r <= CIN ^ SUB;
      idx_r   <= {IW{1'b0}};
    end else if (state_r == ST_RUN) begin
      acc_r   <= acc_nxt_s;
      carry_r <= co_s;
      idx_r   <= idx_r + IW'(1);
      if (last_s) begin
        q_r    <= acc_nxt_s;
        cout_r <= co_s;
        ovf_r  <= msb_cin_s ^ co_s;
        zero_r <= (acc_nxt_s == {W{1'b0}});
      end
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign Q    = q_r;
  assign COUT = cout_r;
  assign OVF  = ovf_r;
  assign ZERO = zero_r;

endmodule

// File: tb/tb_sum16_seq.sv
// Self-checking bench for sum16_seq: a cycle-level arithmetic model checked every
// cycle, plus directed cases with hand-computed results.

module tb_sum16_seq;

  logic        clk, rst_n, start, sub, cin;
  logic [15:0] a, b, q;
  logic        busy, done, cout, ovf, zero;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  sum16_seq #(.NIBBLES(4)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .SUB(sub), .CIN(cin),
    .A(a), .B(b), .BUSY(busy), .DONE(done), .Q(q), .COUT(cout),
    .OVF(ovf), .ZERO(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: full-width arithmetic, result released NIBBLES cycles later
  logic        m_busy, m_done, m_cout, m_ovf, m_zero, p_cout, p_ovf;
  logic [15:0] m_q, p_q, bb;
  logic [16:0] full;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_q = 0; m_cout = 0; m_ovf = 0; m_zero = 0; m_cnt = 0;
    end else if (!m_busy && start) begin
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {16'd0, cin ^ sub};
      p_q    = full[15:0];
      p_cout = full[16];
      p_ovf  = (a[15] == bb[15]) && (p_q[15] != a[15]);
      m_busy = 1; m_done = 0; m_cnt = 4;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_done = 1;
        m_q = p_q; m_cout = p_cout; m_ovf = p_ovf; m_zero = (p_q == 16'h0000);
      end
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_q",    q,    m_q);
      check("cyc_cout", cout, m_cout);
      check("cyc_ovf",  ovf,  m_ovf);
      check("cyc_zero", zero, m_zero);
    end
  end

  task automatic run_op(input string nm, input logic [15:0] ta, tb, input logic ts, tc,
                        input logic [15:0] eq, input logic ec, eo, ez);
    int bcnt;
    bit seen;
    bcnt = 0; seen = 0;
    @(negedge clk); #1;
    a = ta; b = tb; sub = ts; cin = tc; start = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin seen = 1; break; end
      #1 start = 0;
    end
    check({nm, "_done_seen"}, seen, 1);
    check({nm, "_busy_len"}, bcnt, 4);
    check({nm, "_q"}, q, eq);
    check({nm, "_cout"}, cout, ec);
    check({nm, "_ovf"}, ovf, eo);
    check({nm, "_zero"}, zero, ez);
  endtask

  initial begin
    int dcnt, d1, d2, widx;
    rst_n = 1; start = 0; sub = 0; cin = 0; a = 0; b = 0;
    #1 rst_n = 0;
    #22 rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_q", q, 0);
    check("rst_flags", {done, cout, ovf, zero}, 0);

    run_op("add_basic", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
    run_op("sub_borrow",16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0, 0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, 0);
    run_op("sub_cin",   16'h0010, 16'h0003, 1, 1, 16'h000C, 1, 0, 0);

    // START during RUN must be ignored
    @(negedge clk); #1;
    a = 16'h1234; b = 16'h4321; sub = 0; cin = 0; start = 1;
    @(negedge clk); #1 start = 0;
    @(negedge clk); #1 begin start = 1; a = 16'hAAAA; b = 16'h5555; end
    @(negedge clk); #1 start = 0;
    widx = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin widx = k; break; end
    end
    check("ign_done_pos", widx, 1);
    check("ign_q", q, 16'h5555);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("ign_no_second", dcnt, 0);

    // START held for 8 cycles, operands swapped in the DONE cycle
    @(negedge clk); #1;
    a = 16'h1111; b = 16'h2222; sub = 0; cin = 0; start = 1;
    dcnt = 0; d1 = -1; d2 = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcnt++;
        if (d1 < 0) begin
          d1 = k;
          check("b2b_q1", q, 16'h3333);
        end else begin
          d2 = k;
          check("b2b_q2", q, 16'h0E0E);
        end
      end
      if (k == d1 + 1 && d1 >= 0) check("b2b_no_gap", busy, 1);
      if (k == 7) check("b2b_q_hold", q, 16'h3333);
      #1;
      if (done === 1'b1 && d2 < 0) begin a = 16'h0F0F; b = 16'h0101; sub = 1; end
      if (k == 7) start = 0;
    end
    check("b2b_two_dones", dcnt, 2);
    check("b2b_first_pos", d1, 4);

    // reset in the third RUN cycle aborts the operation
    @(negedge clk); #1;
    a = 16'h0F00; b = 16'h00F0; sub = 0; cin = 0; start = 1;
    @(negedge clk); #1 start = 0;
    @(negedge clk);
    @(negedge clk); #1 rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", q, 0);
    check("abort_flags", {cout, ovf, zero}, 0);
    @(negedge clk); #1 rst_n = 1;
    run_op("post_rst", 16'hA5A5, 16'h0101, 0, 0, 16'hA6A6, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      sub   = $urandom_range(0, 1);
      cin   = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
    end
    @(negedge clk); #1 start = 0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
